// File: rtl/rectangle128_sched.sv
// rectangle128_sched: round-robin scheduler feeding two requesters' 64-bit jobs to one cipher core.
// Define RECT_SCHED_TIMEOUT_EN to abort a stuck RUN after TIMEOUT_CYCLES with resp_error=1.
module rectangle128_sched #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic [1:0]   req_valid,
    input  logic [1:0]   req_encrypt,
    input  logic [127:0] req_data,
    output logic [1:0]   req_ready,
    output logic [1:0]   resp_valid,
    input  logic [1:0]   resp_ready,
    output logic [63:0]  resp_data,
    output logic         resp_error,
    output logic         core_enable,
    output logic         core_encrypt,
    output logic [63:0]  core_text,
    input  logic [63:0]  core_result,
    input  logic         core_done,
    input  logic         skey_ready
);
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
    state_t state, state_nxt;
    logic last, owner, gnt, start, timeout, enc_q;
    logic [63:0] text_q, data_q;

    // On a tie the requester not granted last time wins
    assign gnt   = &req_valid ? ~last : req_valid[1];
    assign start = state == IDLE && skey_ready && |req_valid;
    assign req_ready    = (start && !Rst) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign resp_valid   = state == RESP ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign core_enable  = state == RUN;
    assign core_text    = text_q;
    assign core_encrypt = enc_q;
    assign resp_data    = data_q;

    always_ff @(posedge Clk or posedge Rst)
        if (Rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = (core_done || timeout) ? RESP : RUN;
            RESP:    state_nxt = resp_ready[owner] ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            last   <= 1'b1;
            owner  <= 1'b0;
            enc_q  <= 1'b0;
            text_q <= '0;
            data_q <= '0;
        end else begin
            if (start) begin
                last   <= gnt;
                owner  <= gnt;
                enc_q  <= req_encrypt[gnt];
                text_q <= gnt ? req_data[127:64] : req_data[63:0];
            end
            // core_done wins over a coincident timeout
            if (state == RUN && (core_done || timeout))
                data_q <= core_done ? core_result : '0;
        end

`ifdef RECT_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt;
    logic err_q;

    always_ff @(posedge Clk or posedge Rst)
        if (Rst) cnt <= '0;
        else if (start) cnt <= '0;
        else if (state == RUN) cnt <= cnt + CW'(1);

    assign timeout = state == RUN && cnt == LIM;

    always_ff @(posedge Clk or posedge Rst)
        if (Rst) err_q <= 1'b0;
        else if (state == RUN && core_done) err_q <= 1'b0;
        else if (timeout) err_q <= 1'b1;

    assign resp_error = err_q;
`else
    assign timeout    = 1'b0;
    assign resp_error = 1'b0;
`endif
endmodule

// File: tb/tb_rectangle128_sched.sv
// tb_rectangle128_sched: directed checks of arbitration, core handshake, response hold and reset.
module tb_rectangle128_sched;
    logic         Clk = 1'b0;
    logic         Rst;
    logic [1:0]   req_valid, req_encrypt, req_ready, resp_valid, resp_ready;
    logic [127:0] req_data;
    logic [63:0]  resp_data, core_text, core_result;
    logic         resp_error, core_enable, core_encrypt, core_done, skey_ready;
    int errors = 0;
    int checks = 0;

    rectangle128_sched #(.TIMEOUT_CYCLES(64)) dut (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_encrypt(req_encrypt),
        .req_data(req_data), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_error(resp_error),
        .core_enable(core_enable), .core_encrypt(core_encrypt), .core_text(core_text),
        .core_result(core_result), .core_done(core_done), .skey_ready(skey_ready)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    // Called in IDLE with requests already driven; runs one job to acceptance.
    task automatic run_job(input logic [1:0] who, input logic [63:0] text, input logic enc,
                           input int lat, input logic [63:0] res);
        #1;
        chk("grant", req_ready, who);
        chk("idle_en_low", core_enable, 0);
        cyc();
        chk("run_en", core_enable, 1);
        chk("run_text", core_text, text);
        chk("run_enc", core_encrypt, enc);
        chk("run_no_ready", req_ready, 0);
        for (int i = 2; i <= lat; i++) begin
            cyc();
            chk("run_hold_en", core_enable, 1);
            chk("run_hold_text", core_text, text);
            chk("run_no_resp", resp_valid, 0);
        end
        core_done = 1'b1;
        core_result = res;
        cyc();
        core_done = 1'b0;
        core_result = 64'h0;
        #1;
        chk("resp_valid", resp_valid, who);
        chk("resp_data", resp_data, res);
        chk("resp_error", resp_error, 0);
        chk("resp_en_low", core_enable, 0);
        chk("resp_no_ready", req_ready, 0);
        resp_ready = who;
        cyc();
        resp_ready = 2'b00;
        #1;
        chk("post_resp", resp_valid, 0);
    endtask

    initial begin
        Rst = 1'b1;
        req_valid = 2'b01;
        req_encrypt = 2'b00;
        req_data = '0;
        resp_ready = 2'b00;
        core_result = 64'h0;
        core_done = 1'b0;
        skey_ready = 1'b1;
        cyc();
        cyc();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_core_en", core_enable, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_core_text", core_text, 0);
        chk("rst_core_enc", core_encrypt, 0);
        chk("rst_resp_err", resp_error, 0);
        req_valid = 2'b00;
        Rst = 1'b0;
        cyc();

        // Continuous tie: alternation starting with requester 0
        req_valid = 2'b11;
        req_encrypt = 2'b10;
        req_data = {64'hBBBB_0000_1111_2222, 64'hAAAA_3333_4444_5555};
        run_job(2'b01, 64'hAAAA_3333_4444_5555, 1'b0, 3, 64'h1);
        run_job(2'b10, 64'hBBBB_0000_1111_2222, 1'b1, 2, 64'h2);
        run_job(2'b01, 64'hAAAA_3333_4444_5555, 1'b0, 1, 64'h3);
        run_job(2'b10, 64'hBBBB_0000_1111_2222, 1'b1, 4, 64'h4);

        // Single requester 0 encrypt, 28-cycle core
        req_valid = 2'b01;
        req_encrypt = 2'b01;
        req_data = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0123456789ABCDEF};
        run_job(2'b01, 64'h0123456789ABCDEF, 1'b1, 28, 64'hDEADBEEF00C0FFEE);

        // Round keys not ready: nothing granted
        req_valid = 2'b10;
        req_encrypt = 2'b00;
        skey_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("skey_block", req_ready, 0);
            chk("skey_en_low", core_enable, 0);
            cyc();
        end
        skey_ready = 1'b1;
        run_job(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2, 64'h5);

        // Core done in IDLE is ignored
        req_valid = 2'b00;
        core_done = 1'b1;
        core_result = 64'h77;
        cyc();
        core_done = 1'b0;
        cyc();
        chk("idle_done_ign_resp", resp_valid, 0);
        chk("idle_done_ign_en", core_enable, 0);
        chk("idle_done_ign_data", resp_data, 64'h5);

        // Owner stalls response; non-owner ready is ignored
        req_valid = 2'b11;
        req_data = {64'h2222, 64'h1111};
        #1;
        chk("stall_grant", req_ready, 2'b01);
        cyc();
        cyc();
        core_done = 1'b1;
        core_result = 64'hCAFE_F00D_1234_5678;
        cyc();
        core_done = 1'b0;
        core_result = 64'h0;
        resp_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_valid", resp_valid, 2'b01);
            chk("stall_data", resp_data, 64'hCAFE_F00D_1234_5678);
            chk("stall_no_grant", req_ready, 0);
            cyc();
        end
        resp_ready = 2'b01;
        cyc();
        resp_ready = 2'b00;
        #1;
        chk("stall_next_grant", req_ready, 2'b10);

        // Reset mid-RUN abandons job; tie priority returns to requester 0
        cyc();
        cyc();
        chk("pre_rst_en", core_enable, 1);
        Rst = 1'b1;
        #1;
        chk("arst_en", core_enable, 0);
        chk("arst_text", core_text, 0);
        chk("arst_data", resp_data, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_valid", resp_valid, 0);
        cyc();
        Rst = 1'b0;
        #1;
        chk("post_rst_valid", resp_valid, 0);
        run_job(2'b01, 64'h1111, 1'b0, 2, 64'h9);

`ifdef RECT_SCHED_TIMEOUT_EN
        req_valid = 2'b10;
        #1;
        chk("to_grant", req_ready, 2'b10);
        for (int i = 0; i < 64; i++) begin
            cyc();
            chk("to_run_en", core_enable, 1);
        end
        req_valid = 2'b00;
        cyc();
        #1;
        chk("to_valid", resp_valid, 2'b10);
        chk("to_error", resp_error, 1);
        chk("to_data", resp_data, 0);
        chk("to_en_low", core_enable, 0);
        resp_ready = 2'b10;
        cyc();
        resp_ready = 2'b00;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
